efuse_prog_sequencer: RTL

//  Consumes the fixed-width start_pulse (7 clk_8M cycles high) from the start generator and runs one

---
 rtl/efuse_pkg.sv | 25 ++
 rtl/efuse_timer.sv | 42 ++++
 rtl/efuse_prog_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/efuse_pkg.sv
// Shared definitions for the eFuse access sequencer: default geometry and timing,
// FSM state encoding and a small helper for sizing the shared phase counter.
package efuse_pkg;

  localparam int unsigned DefNbits    = 32;
  localparam int unsigned DefAddrW    = 5;
  localparam int unsigned DefSetupCyc = 2;
  localparam int unsigned DefProgCyc  = 40;  // 5 us at 8 MHz
  localparam int unsigned DefReadCyc  = 4;
  localparam int unsigned DefHoldCyc  = 2;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSetup  = 3'd1,
    StStrobe = 3'd2,
    StHold   = 3'd3,
    StNext   = 3'd4,
    StDone   = 3'd5
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/efuse_timer.sv
// Loadable down-counter shared by the SETUP, STROBE and HOLD phases.
// Ports:
//   clk_8M    system clock
//   rst       asynchronous active-low reset
//   load      load load_val this cycle (takes priority over counting)
//   load_val  value to load, phase length minus one
//   value     current count
//   zero      count has reached zero (counter saturates there)
module efuse_timer #(
  parameter int unsigned CntW = 6
) (
  input  logic            clk_8M,
  input  logic            rst,
  input  logic            load,
  input  logic [CntW-1:0] load_val,
  output logic [CntW-1:0] value,
  output logic            zero
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_8M or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/efuse_prog_sequencer.sv
// Runs one complete eFuse access per start_pulse rising edge: programs or reads all NBITS
// fuse bits serially with one timed strobe per bit, and owns all macro-facing timing.
// Ports:
//   clk_8M        system clock, 8 MHz
//   rst           asynchronous active-low reset
//   start_pulse   multi-cycle start request; only its rising edge triggers
//   mode          1 = program, 0 = read; sampled on trigger
//   prog_data     word to burn; sampled on trigger
//   efuse_q       macro read output for the addressed bit
//   efuse_csb     macro chip select, active low
//   efuse_pgm     macro program enable
//   efuse_strobe  macro program/read strobe
//   efuse_addr    addressed bit
//   busy          high from the cycle after trigger through the done cycle
//   done          one-cycle pulse at the end of an access
//   read_data     word captured by the last read; untouched by program accesses
module efuse_prog_sequencer
  import efuse_pkg::*;
#(
  parameter int unsigned NBITS     = DefNbits,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned SETUP_CYC = DefSetupCyc,
  parameter int unsigned PROG_CYC  = DefProgCyc,
  parameter int unsigned READ_CYC  = DefReadCyc,
  parameter int unsigned HOLD_CYC  = DefHoldCyc
) (
  input  logic              clk_8M,
  input  logic              rst,
  input  logic              start_pulse,
  input  logic              mode,
  input  logic [NBITS-1:0]  prog_data,
  input  logic              efuse_q,
  output logic              efuse_csb,
  output logic              efuse_pgm,
  output logic              efuse_strobe,
  output logic [ADDR_W-1:0] efuse_addr,
  output logic              busy,
  output logic              done,
  output logic [NBITS-1:0]  read_data
);

  localparam int unsigned CntMax = max_u(max_u(PROG_CYC, READ_CYC), max_u(SETUP_CYC, HOLD_CYC));
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NBITS - 1);
  localparam logic [CntW-1:0]   SetupLd  = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0]   ProgLd   = CntW'(PROG_CYC - 1);
  localparam logic [CntW-1:0]   ReadLd   = CntW'(READ_CYC - 1);
  localparam logic [CntW-1:0]   HoldLd   = CntW'(HOLD_CYC - 1);

  state_e state_q, state_d;

  logic              start_d_q;
  logic              trigger;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mode_q, mode_d;
  logic [NBITS-1:0]  data_q, data_d;
  logic [NBITS-1:0]  rdata_q, rdata_d;

  logic              tmr_load;
  logic [CntW-1:0]   tmr_load_val;
  logic [CntW-1:0]   tmr_value;
  logic              tmr_zero;

  logic csb_q, csb_d;
  logic pgm_q, pgm_d;
  logic strobe_q, strobe_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Rising-edge detect: later high cycles of the same pulse never retrigger.
  always_ff @(posedge clk_8M or negedge rst) begin
    if (!rst) begin
      start_d_q <= 1'b0;
    end else begin
      start_d_q <= start_pulse;
    end
  end

  assign trigger = start_pulse & ~start_d_q;

  efuse_timer #(
    .CntW (CntW)
  ) u_timer (
    .clk_8M   (clk_8M),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  // State register
  always_ff @(posedge clk_8M or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, timer loads, address and request latches
  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = SetupLd;
    addr_d       = addr_q;
    mode_d       = mode_q;
    data_d       = data_q;
    unique case (state_q)
      StIdle: begin
        // Triggers while busy are simply dropped: only this state looks at them.
        if (trigger) begin
          state_d      = StSetup;
          tmr_load     = 1'b1;
          tmr_load_val = SetupLd;
          addr_d       = '0;
          mode_d       = mode;
          data_d       = prog_data;
        end
      end
      StSetup: begin
        if (tmr_zero) begin
          // Bits that stay unburnt need no strobe at all.
          if (mode_q && !data_q[addr_q]) begin
            state_d = StNext;
          end else begin
            state_d      = StStrobe;
            tmr_load     = 1'b1;
            tmr_load_val = mode_q ? ProgLd : ReadLd;
          end
        end
      end
      StStrobe: begin
        if (tmr_zero) begin
          state_d      = StHold;
          tmr_load     = 1'b1;
          tmr_load_val = HoldLd;
        end
      end
      StHold: begin
        if (tmr_zero) begin
          state_d = StNext;
        end
      end
      StNext: begin
        if (addr_q == LastAddr) begin
          state_d = StDone;
        end else begin
          state_d      = StSetup;
          tmr_load     = 1'b1;
          tmr_load_val = SetupLd;
          addr_d       = addr_q + ADDR_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Read capture on the last strobe cycle, when the macro output has had the full strobe to settle.
  always_comb begin
    rdata_d = rdata_q;
    if (state_q == StStrobe && !mode_q && tmr_value == '0) begin
      rdata_d[addr_q] = efuse_q;
    end
  end

  always_ff @(posedge clk_8M or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      mode_q  <= 1'b0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decoded from the next state so the registered outputs line up with state_q.
  always_comb begin
    csb_d    = 1'b1;
    pgm_d    = 1'b0;
    strobe_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state_d)
      StSetup, StHold, StNext: begin
        csb_d  = 1'b0;
        pgm_d  = mode_d;
        busy_d = 1'b1;
      end
      StStrobe: begin
        csb_d    = 1'b0;
        pgm_d    = mode_d;
        strobe_d = 1'b1;
        busy_d   = 1'b1;
      end
      StDone: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        csb_d = 1'b1;
      end
    endcase
  end

  // Async reset drops strobe/pgm and deselects the macro without waiting for a clock.
  always_ff @(posedge clk_8M or negedge rst) begin
    if (!rst) begin
      csb_q    <= 1'b1;
      pgm_q    <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      csb_q    <= csb_d;
      pgm_q    <= pgm_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign efuse_csb    = csb_q;
  assign efuse_pgm    = pgm_q;
  assign efuse_strobe = strobe_q;
  assign efuse_addr   = addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign read_data    = rdata_q;

endmodule
